// File: rtl/div_pwm_pkg.sv
// rtl/div_pwm_pkg.sv - shared FSM state and rate-select encodings for div_pwm_gen
package div_pwm_pkg;

  // Controller states: IDLE parks the counter, RUN counts, STOP drains to the wrap
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Tick source selection
  typedef enum logic [1:0] {
    RATE_CLK = 2'b00,
    RATE_F2  = 2'b01,
    RATE_F4  = 2'b10,
    RATE_F8  = 2'b11
  } rate_t;

endpackage

// File: rtl/div_pwm_gen_if.sv
// rtl/div_pwm_gen_if.sv - divider inputs, PWM controls and PWM status bundle
interface div_pwm_gen_if #(
  parameter int WIDTH = 8
);

  logic             f2;
  logic             f4;
  logic             f8;
  logic [1:0]       rate_sel;
  logic             enable;
  logic [WIDTH-1:0] duty;
  logic             duty_load;
  logic             pwm_out;
  logic             period_done;
  logic             tick;
  logic             busy;

  // Driver side: divider outputs and control inputs, observes the PWM status
  modport master (
    output f2, f4, f8, rate_sel, enable, duty, duty_load,
    input  pwm_out, period_done, tick, busy
  );

  // PWM generator side
  modport slave (
    input  f2, f4, f8, rate_sel, enable, duty, duty_load,
    output pwm_out, period_done, tick, busy
  );

endinterface

// File: rtl/div_pwm_gen_rise_tick_sel.sv
// rtl/div_pwm_gen_rise_tick_sel.sv - divided-clock edge register, 4:1 select and rising-edge tick
module rise_tick_sel
  import div_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  f2,
  input  logic  f4,
  input  logic  f8,
  input  rate_t rate_act,
  output logic  raw_tick
);

  logic f2_q;
  logic f4_q;
  logic f8_q;

  // Delay each divider output by one clk; reset to 0 so a high input right after reset reads as a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      f2_q <= 1'b0;
      f4_q <= 1'b0;
      f8_q <= 1'b0;
    end else begin
      f2_q <= f2;
      f4_q <= f4;
      f8_q <= f8;
    end
  end

  // Select the active source and turn its rising edge into a one-clk enable
  always_comb begin
    raw_tick = 1'b0;
    unique case (rate_act)
      RATE_CLK: raw_tick = 1'b1;
      RATE_F2:  raw_tick = f2 & ~f2_q;
      RATE_F4:  raw_tick = f4 & ~f4_q;
      RATE_F8:  raw_tick = f8 & ~f8_q;
      default:  raw_tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/div_pwm_gen.sv
// rtl/div_pwm_gen.sv - tick-driven PWM generator; PWM_CENTER_ALIGN_EN selects up/down counting
module div_pwm_gen
  import div_pwm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 256
) (
  input logic          clk,
  input logic          rst,
  div_pwm_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

  generate
    if (PERIOD < 2 || PERIOD > (1 << WIDTH)) begin : g_period_check
      $error("div_pwm_gen: PERIOD must lie in 2..2**WIDTH");
    end
  endgenerate

  state_t           state;
  state_t           state_nx;
  rate_t            rate_act;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] duty_pend;
  logic [WIDTH-1:0] duty_act;
  logic             raw_tick;
  logic             wrap;
  logic             pwm_q;
  logic             done_q;
  logic             tick_q;

  rise_tick_sel u_rise_tick_sel (
    .clk      (clk),
    .rst      (rst),
    .f2       (bus.f2),
    .f4       (bus.f4),
    .f8       (bus.f8),
    .rate_act (rate_act),
    .raw_tick (raw_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: STOP finishes the running period before parking; re-enable resumes seamlessly
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.enable) state_nx = RUN;
      RUN:  if (!bus.enable) state_nx = STOP;
      STOP: begin
        if (bus.enable) begin
          state_nx = RUN;
        end else if (wrap) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_down;
  logic dir_down_nx;

  // Triangle counter: up to CNT_LAST, down to 0; the bottom turnaround is the period boundary
  always_comb begin
    cnt_nx      = cnt;
    dir_down_nx = dir_down;
    if (raw_tick && state != IDLE) begin
      if (dir_down) begin
        if (cnt == '0) begin
          cnt_nx      = WIDTH'(1);
          dir_down_nx = 1'b0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end else begin
        if (cnt == CNT_LAST) begin
          cnt_nx      = cnt - 1'b1;
          dir_down_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    end
    if (state_nx == IDLE) begin
      cnt_nx      = '0;
      dir_down_nx = 1'b0;
    end
  end

  assign wrap = (state != IDLE) && raw_tick && dir_down && (cnt == '0);

  // Direction register
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_down <= 1'b0;
    end else begin
      dir_down <= dir_down_nx;
    end
  end
`else
  // Sawtooth counter: 0..CNT_LAST then back to 0 on the wrap tick
  always_comb begin
    cnt_nx = cnt;
    if (raw_tick && state != IDLE) begin
      cnt_nx = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
    if (state_nx == IDLE) begin
      cnt_nx = '0;
    end
  end

  assign wrap = (state != IDLE) && raw_tick && (cnt == CNT_LAST);
`endif

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end

  // Duty shadowing: pending takes loads any time, active only changes at start or on a wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pend <= '0;
      duty_act  <= '0;
    end else begin
      if (bus.duty_load) begin
        duty_pend <= bus.duty;
      end
      if (state == IDLE && state_nx == RUN) begin
        duty_act <= duty_pend;
      end else if (wrap) begin
        duty_act <= bus.duty_load ? bus.duty : duty_pend;
      end
    end
  end

  // Rate source follows rate_sel while parked, otherwise only at period boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_act <= RATE_CLK;
    end else if (state == IDLE || wrap) begin
      rate_act <= rate_t'(bus.rate_sel);
    end
  end

  // Registered outputs; duty_act >= PERIOD holds pwm high and 0 holds it low since cnt < PERIOD
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q  <= 1'b0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pwm_q  <= (state != IDLE) && (cnt < duty_act);
      done_q <= wrap;
      tick_q <= raw_tick;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_done = done_q;
  assign bus.tick        = tick_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_div_pwm_gen.sv
// tb/tb_div_pwm_gen.sv - self-checking bench for div_pwm_gen (WIDTH=4, PERIOD=10)
module tb_div_pwm_gen;

  localparam int WIDTH  = 4;
  localparam int PERIOD = 10;

  logic clk;
  logic rst;
  logic [3:0] div_cnt;

  div_pwm_gen_if #(.WIDTH(WIDTH)) bus ();

  div_pwm_gen #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 run, 2 stop; pos is the tick position in the period
  int       m_mode, m_pos, m_dact, m_dpend, m_ract;
  bit [2:0] m_fq;
  bit       m_pwm, m_pd, m_tk;

  typedef struct {
    logic [1:0] rate;
    logic [3:0] duty;
    int         exp_high;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit [2:0] f_now;
    bit       t, last, active;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_dact = 0; m_dpend = 0; m_ract = 0;
      m_fq = '0; m_pwm = 0; m_pd = 0; m_tk = 0;
      return;
    end
    f_now  = {bus.f8, bus.f4, bus.f2};
    t      = (m_ract == 0) || (f_now[m_ract-1] && !m_fq[m_ract-1]);
    active = (m_mode != 0);
    last   = active && t && (m_pos == PERIOD - 1);
    m_pwm  = active && ((m_dact >= PERIOD) ? 1'b1 : (m_dact == 0) ? 1'b0 : (m_pos < m_dact));
    m_pd   = last;
    m_tk   = t;
    m_fq   = f_now;
    if (m_mode == 0) begin
      m_pos  = 0;
      m_ract = int'(bus.rate_sel);
      if (bus.enable) begin
        m_dact = m_dpend;
        m_mode = 1;
      end
    end else begin
      if (t) m_pos = last ? 0 : m_pos + 1;
      if (last) begin
        m_ract = int'(bus.rate_sel);
        m_dact = bus.duty_load ? int'(bus.duty) : m_dpend;
      end
      if (m_mode == 1) begin
        if (!bus.enable) m_mode = 2;
      end else if (bus.enable) begin
        m_mode = 1;
      end else if (last) begin
        m_mode = 0;
        m_pos  = 0;
      end
    end
    if (bus.duty_load) m_dpend = int'(bus.duty);
  endtask

  // One clock: advance the model, let the DUT clock, advance the free-running divider, compare
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    div_cnt = div_cnt + 4'd1;
    bus.f2  = div_cnt[0];
    bus.f4  = div_cnt[1];
    bus.f8  = div_cnt[2];
    check("cycle_outputs", {28'd0, bus.pwm_out, bus.period_done, bus.tick, bus.busy},
          {28'd0, m_pwm, m_pd, m_tk, (m_mode != 0)});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    rst = 1'b0;
  endtask

  task automatic load_duty(input logic [3:0] d);
    bus.duty      = d;
    bus.duty_load = 1'b1;
    cyc();
    bus.duty_load = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.period_done && n < 300) begin
      cyc();
      n++;
    end
    check({nm, "_sync"}, {31'd0, bus.period_done}, 32'd1);
  endtask

  // Starting at a period_done cycle, count pwm highs and length up to the next period_done
  task automatic measure(input int exp_high, input int exp_len, input string nm);
    int hi, len;
    wait_done(nm);
    hi  = 0;
    len = 0;
    do begin
      hi += int'(bus.pwm_out);
      cyc();
      len++;
    end while (!bus.period_done && len < 300);
    check({nm, "_high"}, hi, exp_high);
    check({nm, "_len"}, len, exp_len);
  endtask

  initial begin
    int hi, n, pds;
    vecs[0] = '{rate: 2'b00, duty: 4'd3,  exp_high: 3,  exp_len: 10};
    vecs[1] = '{rate: 2'b11, duty: 4'd5,  exp_high: 40, exp_len: 80};
    vecs[2] = '{rate: 2'b01, duty: 4'd7,  exp_high: 14, exp_len: 20};
    vecs[3] = '{rate: 2'b10, duty: 4'd0,  exp_high: 0,  exp_len: 40};
    vecs[4] = '{rate: 2'b00, duty: 4'd15, exp_high: 10, exp_len: 10};
    vecs[5] = '{rate: 2'b10, duty: 4'd10, exp_high: 40, exp_len: 40};
    vecs[6] = '{rate: 2'b01, duty: 4'd1,  exp_high: 2,  exp_len: 20};

    rst = 1'b1;
    div_cnt = '0;
    bus.f2 = 1'b0; bus.f4 = 1'b0; bus.f8 = 1'b0;
    bus.rate_sel = 2'b00; bus.enable = 1'b0; bus.duty = '0; bus.duty_load = 1'b0;

    // Reset and idle
    do_reset(3);
    check("reset_outputs", {29'd0, bus.pwm_out, bus.period_done, bus.busy}, 32'd0);
    hi = 0; pds = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      hi  += int'(bus.pwm_out);
      pds += int'(bus.period_done);
      n   += int'(bus.busy);
    end
    check("idle_pwm", hi, 0);
    check("idle_done", pds, 0);
    check("idle_busy", n, 0);

    // Table: steady-state high time and period length for each rate/duty
    foreach (vecs[k]) begin
      bus.enable = 1'b0;
      do_reset(2);
      bus.rate_sel = vecs[k].rate;
      load_duty(vecs[k].duty);
      bus.enable = 1'b1;
      measure(vecs[k].exp_high, vecs[k].exp_len, $sformatf("vec%0d", k));
    end

    // Duty shadow: mid-period load waits for the wrap, wrap-cycle load applies at once
    bus.enable = 1'b0;
    do_reset(2);
    bus.rate_sel = 2'b00;
    load_duty(4'd3);
    bus.enable = 1'b1;
    measure(3, 10, "shadow_base");
    for (int i = 0; i < 4; i++) cyc();
    load_duty(4'd8);
    hi = 0; n = 0;
    while (!bus.period_done && n < 50) begin
      hi += int'(bus.pwm_out);
      cyc();
      n++;
    end
    check("shadow_rest_of_period", hi, 0);
    measure(8, 10, "shadow_next");
    for (int i = 0; i < 9; i++) cyc();
    load_duty(4'd5);
    check("bypass_wrap", {31'd0, bus.period_done}, 32'd1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(bus.pwm_out);
      cyc();
    end
    check("bypass_high", hi, 5);
    check("bypass_next_wrap", {31'd0, bus.period_done}, 32'd1);

    // Stop drains to the wrap at cnt = 4
    bus.enable = 1'b0;
    do_reset(2);
    load_duty(4'd3);
    bus.enable = 1'b1;
    wait_done("stop");
    for (int i = 0; i < 4; i++) cyc();
    bus.enable = 1'b0;
    n = 0; pds = 0;
    while (bus.busy && n < 50) begin
      cyc();
      n++;
      pds += int'(bus.period_done);
    end
    check("stop_drain_cycles", n, 6);
    check("stop_done_pulses", pds, 1);
    pds = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      pds += int'(bus.period_done);
    end
    check("stop_quiet", pds, 0);

    // Reset mid-period at cnt = 6 with enable held high
    bus.enable = 1'b1;
    wait_done("midrst");
    for (int i = 0; i < 6; i++) cyc();
    do_reset(1);
    check("midrst_outputs", {28'd0, bus.pwm_out, bus.period_done, bus.tick, bus.busy}, 32'd0);
    cyc();
    check("midrst_restart_busy", {31'd0, bus.busy}, 32'd1);
    cyc();
    check("midrst_first_pwm", {31'd0, bus.pwm_out}, 32'd0);
    measure(0, 10, "midrst_period");

    // Randomized traffic against the model
    bus.enable = 1'b0;
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
      bus.duty_load = ($urandom_range(0, 5) == 0);
      bus.duty      = 4'($urandom_range(0, 15));
      rst           = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    bus.duty_load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
